// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared widths, constants and FSM state encoding for the
//               THCO-MIPS memory-access stage.
// Contents    : RegBus / MemAddrBus / RegAddrBus widths, ZeroWord,
//               DisableRegAddr, RstEnable, BusErrWord, mem_state_e.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam int RegBus     = 16;
    localparam int MemAddrBus = 16;
    localparam int RegAddrBus = 4;

    localparam logic [RegBus-1:0]     ZeroWord       = '0;
    localparam logic [RegAddrBus-1:0] DisableRegAddr = '0;

    // This block's reset is active-low.
    localparam logic RstEnable = 1'b0;

    // Data returned to a load whose access was abandoned by the watchdog.
    localparam logic [RegBus-1:0] BusErrWord = 16'hFFFF;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

endpackage : mem_access_pkg

`default_nettype wire

// File: rtl/mem_timeout.sv
// ============================================================================
// Module      : mem_timeout
// Description : Watchdog counter for the memory-access stage. Cleared when
//               an access enters WAIT, counts every WAIT cycle and flags
//               expiry on the TIMEOUT_CYCLES-th WAIT cycle.
// Ports       : clk, rst (async, active-low)
//               clear_i   - restart the count (entry to WAIT)
//               run_i     - FSM is in WAIT
//               expired_o - this WAIT cycle is the last one allowed
// Parameters  : TIMEOUT_CYCLES (1..256)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timeout
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (run_i && (cnt_q != LastCount)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // The count equals the number of WAIT cycles already completed, so
    // expiry lands on exactly the TIMEOUT_CYCLES-th cycle spent in WAIT.
    assign expired_o = run_i && (cnt_q == LastCount);

endmodule : mem_timeout

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : MEM stage of the THCO-MIPS pipeline. Runs a req/ack
//               transaction on the data-memory port for loads and stores,
//               stalls the pipeline until it completes, and presents the
//               write-back word to MEM/WB. Non-memory instructions pass
//               straight through with zero latency.
// Ports       : clk, rst (async, active-low)
//               EX/MEM side : memAddr_i, rMem_i, wMem_i, wData_i, wReg_i,
//                             wRegAddr_i, stallIn_i
//               Memory port : memReq_o, memWe_o, memAddr_o, memWData_o,
//                             memRData_i, memAck_i
//               Pipeline    : stallReq_o, wData_o, wReg_o, wRegAddr_o
//               busErr_o    : sticky watchdog flag (MEM_TIMEOUT_EN only)
// Config      : `MEM_TIMEOUT_EN adds the mem_timeout watchdog and busErr_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MemAddrBus-1:0] memAddr_i,
    input  logic                  rMem_i,
    input  logic                  wMem_i,
    input  logic [RegBus-1:0]     wData_i,
    input  logic                  wReg_i,
    input  logic [RegAddrBus-1:0] wRegAddr_i,
    input  logic                  stallIn_i,
    input  logic [RegBus-1:0]     memRData_i,
    input  logic                  memAck_i,
    output logic                  memReq_o,
    output logic                  memWe_o,
    output logic [MemAddrBus-1:0] memAddr_o,
    output logic [RegBus-1:0]     memWData_o,
    output logic                  stallReq_o,
    output logic [RegBus-1:0]     wData_o,
    output logic                  wReg_o,
    output logic [RegAddrBus-1:0] wRegAddr_o
`ifdef MEM_TIMEOUT_EN
   ,output logic                  busErr_o
`endif
);

    mem_state_e          state_q, state_d;
    logic [RegBus-1:0]   rdata_q, rdata_d;
    logic                timeout_hit;

    logic                req;
    logic                wb_en;
    logic [RegBus-1:0]   wb_data;

    // A store wins when both flags are set, so a load is read-only.
    logic is_access, is_load;
    assign is_access = rMem_i | wMem_i;
    assign is_load   = rMem_i & ~wMem_i;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q <= MEM_IDLE;
            rdata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        wb_en   = 1'b0;
        wb_data = ZeroWord;
        unique case (state_q)
            MEM_IDLE: begin
                if (is_access) begin
                    req     = 1'b1;
                    state_d = MEM_WAIT;
                end else begin
                    wb_en   = 1'b1;
                    wb_data = wData_i;
                end
            end
            MEM_WAIT: begin
                req = 1'b1;
                if (memAck_i) begin
                    if (is_load) rdata_d = memRData_i;
                    state_d = MEM_DONE;
                end else if (timeout_hit) begin
                    if (is_load) rdata_d = BusErrWord;
                    state_d = MEM_DONE;
                end
            end
            MEM_DONE: begin
                wb_en   = 1'b1;
                wb_data = is_load ? rdata_q : ZeroWord;
                if (!stallIn_i) state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // Request and stall are gated by rst so that an asynchronous reset drops
    // them at once, even while EX/MEM still presents the memory command.
    assign memReq_o   = req & rst;
    assign stallReq_o = req & rst;
    assign memWe_o    = req & wMem_i;
    assign memAddr_o  = memAddr_i;
    assign memWData_o = wData_i;

    // Stall cycles emit a bubble; a disabled write-back is forced to zeros.
    assign wReg_o     = wb_en & wReg_i;
    assign wData_o    = wReg_o ? wb_data : ZeroWord;
    assign wRegAddr_o = wReg_o ? wRegAddr_i : DisableRegAddr;

`ifdef MEM_TIMEOUT_EN
    logic busErr_q;

    mem_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_mem_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   ((state_q == MEM_IDLE) && is_access),
        .run_i     (state_q == MEM_WAIT),
        .expired_o (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            busErr_q <= 1'b0;
        end else if (timeout_hit && !memAck_i) begin
            busErr_q <= 1'b1;
        end
    end

    assign busErr_o = busErr_q;
`else
    // Without the watchdog WAIT only ends on memAck_i.
    assign timeout_hit = 1'b0;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule : mem_access

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access. A behavioural memory
//               slave answers the DUT port; a separate reference memory and
//               transaction-level rules give every expected value.
// Config      : `MEM_TIMEOUT_EN also exercises the watchdog and busErr_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

    logic        clk;
    logic        rst;
    logic [15:0] memAddr_i;
    logic        rMem_i;
    logic        wMem_i;
    logic [15:0] wData_i;
    logic        wReg_i;
    logic [3:0]  wRegAddr_i;
    logic        stallIn_i;
    logic [15:0] memRData_i;
    logic        memAck_i;
    logic        memReq_o;
    logic        memWe_o;
    logic [15:0] memAddr_o;
    logic [15:0] memWData_o;
    logic        stallReq_o;
    logic [15:0] wData_o;
    logic        wReg_o;
    logic [3:0]  wRegAddr_o;
`ifdef MEM_TIMEOUT_EN
    logic        busErr_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int to_stalls;

    // Slave memory (driven by DUT port) and reference memory (driven by the
    // transaction list) are kept apart so a wrong address or data shows up.
    logic [15:0] slave_mem [logic [15:0]];
    logic [15:0] ref_mem   [logic [15:0]];

    mem_access #(
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memAddr_i  (memAddr_i),
        .rMem_i     (rMem_i),
        .wMem_i     (wMem_i),
        .wData_i    (wData_i),
        .wReg_i     (wReg_i),
        .wRegAddr_i (wRegAddr_i),
        .stallIn_i  (stallIn_i),
        .memRData_i (memRData_i),
        .memAck_i   (memAck_i),
        .memReq_o   (memReq_o),
        .memWe_o    (memWe_o),
        .memAddr_o  (memAddr_o),
        .memWData_o (memWData_o),
        .stallReq_o (stallReq_o),
        .wData_o    (wData_o),
        .wReg_o     (wReg_o),
        .wRegAddr_o (wRegAddr_o)
`ifdef MEM_TIMEOUT_EN
       ,.busErr_o   (busErr_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] slave_read(input logic [15:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
    endfunction

    // One instruction through the stage. dly = extra WAIT cycles before ack,
    // hold = cycles stallIn_i is held while the result sits in DONE.
    task automatic run_txn(input logic r, input logic w, input logic wr,
                           input logic [3:0] ra, input logic [15:0] addr,
                           input logic [15:0] wd, input int dly, input int hold);
        logic [15:0] exp_wb;
        logic [3:0]  exp_ra;
        if (r && !w)  exp_wb = ref_read(addr);
        else if (w)   exp_wb = 16'h0000;
        else          exp_wb = wd;
        if (w) ref_mem[addr] = wd;
        if (!wr) exp_wb = 16'h0000;
        exp_ra = wr ? ra : 4'd0;

        @(posedge clk); #1;
        rMem_i = r; wMem_i = w; wReg_i = wr; wRegAddr_i = ra;
        memAddr_i = addr; wData_i = wd; stallIn_i = 1'b0;
        memAck_i = 1'($urandom_range(0, 1));
        memRData_i = 16'($urandom);

        if (!(r || w)) begin
            #1;
            check_eq("alu_stall", stallReq_o, 0);
            check_eq("alu_req",   memReq_o,   0);
            check_eq("alu_wdata", wData_o,    exp_wb);
            check_eq("alu_wreg",  wReg_o,     wr);
            check_eq("alu_waddr", wRegAddr_o, exp_ra);
            return;
        end

        // IDLE cycle plus dly+1 WAIT cycles, all stalled.
        for (int c = 0; c < dly + 2; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                memAck_i   = (c == dly + 1);
                memRData_i = 16'($urandom);
            end
            #1;
            if (c > 0 && memAck_i) begin
                if (memWe_o) slave_mem[memAddr_o] = memWData_o;
                else         memRData_i = slave_read(memAddr_o);
            end
            @(negedge clk);
            check_eq("acc_stall", stallReq_o, 1);
            check_eq("acc_req",   memReq_o,   1);
            check_eq("acc_we",    memWe_o,    w);
            check_eq("acc_addr",  memAddr_o,  addr);
            if (w) check_eq("acc_wd", memWData_o, wd);
        end

        // DONE, held for hold extra cycles by stallIn_i.
        for (int c = 0; c <= hold; c++) begin
            @(posedge clk); #1;
            memAck_i   = 1'($urandom_range(0, 1));
            memRData_i = 16'($urandom);
            stallIn_i  = (c < hold);
            @(negedge clk);
            check_eq("done_stall", stallReq_o, 0);
            check_eq("done_req",   memReq_o,   0);
            check_eq("done_wdata", wData_o,    exp_wb);
            check_eq("done_wreg",  wReg_o,     wr);
            check_eq("done_waddr", wRegAddr_o, exp_ra);
        end
        stallIn_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        memAddr_i = '0; rMem_i = 0; wMem_i = 0; wData_i = '0; wReg_i = 0;
        wRegAddr_i = '0; stallIn_i = 0; memRData_i = '0; memAck_i = 0;
        slave_mem[16'h8000] = 16'hBEEF;
        ref_mem[16'h8000]   = 16'hBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req",   memReq_o,   0);
        check_eq("rst_stall", stallReq_o, 0);
        check_eq("rst_wdata", wData_o,    16'h0000);
        check_eq("rst_waddr", wRegAddr_o, 4'd0);
`ifdef MEM_TIMEOUT_EN
        check_eq("rst_buserr", busErr_o, 0);
`endif
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_stall", stallReq_o, 0);

        // Directed cases.
        run_txn(0, 0, 1, 4'd3, 16'h0000, 16'h1234, 0, 0);   // ALU pass-through
        run_txn(1, 0, 1, 4'd5, 16'h8000, 16'h0000, 0, 0);   // load, immediate ack
        run_txn(0, 1, 0, 4'd0, 16'h4010, 16'h00A5, 2, 0);   // store, 4 stall cycles
        run_txn(1, 0, 1, 4'd6, 16'h4010, 16'h0000, 1, 2);   // read-back, DONE held 2
        run_txn(1, 1, 1, 4'd2, 16'h0101, 16'h7777, 0, 1);   // both set: store wins
        run_txn(1, 0, 1, 4'd1, 16'h0101, 16'h0000, 0, 0);   // sees the store
        run_txn(1, 0, 0, 4'd9, 16'h0102, 16'h0000, 3, 0);   // load with wReg=0

        // Reset in the middle of WAIT.
        @(posedge clk); #1;
        rMem_i = 1; wMem_i = 0; wReg_i = 1; wRegAddr_i = 4'd4;
        memAddr_i = 16'h0105; wData_i = 16'h3C3C; memAck_i = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("midwait_req", memReq_o, 1);
        #1 rst = 1'b0;
        #1;
        check_eq("rstwait_req",   memReq_o,   0);
        check_eq("rstwait_stall", stallReq_o, 0);
        rMem_i = 0;
        #1;
        check_eq("rstwait_pass", wData_o, 16'h3C3C);
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rstrel_stall", stallReq_o, 0);
        check_eq("rstrel_wdata", wData_o,    16'h3C3C);
        check_eq("rstrel_waddr", wRegAddr_o, 4'd4);

        // Randomized instruction stream over a small address window.
        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            run_txn(kind == 1 || kind == 3, kind >= 2, 1'($urandom_range(0, 1)),
                    4'($urandom), 16'h0100 + 16'($urandom_range(0, 7)),
                    16'($urandom), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 2)));
        end

`ifdef MEM_TIMEOUT_EN
        // Load with no ack: the watchdog ends WAIT after 255 cycles.
        @(posedge clk); #1;
        rMem_i = 1; wMem_i = 0; wReg_i = 1; wRegAddr_i = 4'd7;
        memAddr_i = 16'h0200; wData_i = 16'h0000; memAck_i = 0; stallIn_i = 0;
        to_stalls = 0;
        @(negedge clk);
        while (stallReq_o && to_stalls < 400) begin
            to_stalls++;
            @(negedge clk);
        end
        check_eq("to_stalls", to_stalls, 256);
        check_eq("to_wdata",  wData_o,   16'hFFFF);
        check_eq("to_buserr", busErr_o,  1);
        @(posedge clk); #1;
        rMem_i = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("to_sticky", busErr_o, 1);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_access

`default_nettype wire

// File: doc/mem_access.md
# mem_access

Memory-access stage of the THCO-MIPS pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It takes the registered memory command (address, read/write flags, write-back data) and runs a request/acknowledge transaction on the shared data-memory port. It stalls the pipeline until the access completes, then presents the final write-back data (loaded word or passed-through ALU result) to MEM/WB.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only with `MEM_TIMEOUT_EN`.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- memAddr_i  in  16  word address from EX/MEM.
- rMem_i  in  1  load request.
- wMem_i  in  1  store request.
- wData_i  in  16  ALU result for non-memory instructions, or store data when wMem_i=1.
- wReg_i  in  1  register write-back enable.
- wRegAddr_i  in  4  destination register.
- stallIn_i  in  1  stall[4] from the stall controller (MEM/WB held).
- memRData_i  in  16  read data from the memory port.
- memAck_i  in  1  memory port completion strobe.
- memReq_o  out  1  access request.
- memWe_o  out  1  1 = write, 0 = read.
- memAddr_o  out  16  access address.
- memWData_o  out  16  store data.
- stallReq_o  out  1  pipeline stall request (stall bits 0..3).
- wData_o  out  16  write-back data to MEM/WB.
- wReg_o  out  1  write-back enable to MEM/WB.
- wRegAddr_o  out  4  write-back register to MEM/WB.
- busErr_o  out  1  sticky timeout flag; exists only with `MEM_TIMEOUT_EN`.

## Operation
- The FSM has three states: IDLE, WAIT and DONE. Reset forces IDLE and clears the read-data latch, the counter and busErr_o.
- **IDLE, with rMem_i or wMem_i set:**
  - memReq_o=1 and stallReq_o=1, both combinational.
  - memWe_o=wMem_i, memAddr_o=memAddr_i, memWData_o=wData_i.
  - Next state: WAIT.
  - If both rMem_i and wMem_i are set, the write wins.
- **IDLE, no access:** memReq_o=0 and stallReq_o=0. Outputs pass through: wData_o=wData_i, wReg_o=wReg_i, wRegAddr_o=wRegAddr_i.
- **WAIT:**
  - memReq_o, memWe_o, memAddr_o and memWData_o are held from the inputs, which are stable because EX/MEM is stalled. stallReq_o=1.
  - On memAck_i=1: latch memRData_i (reads only) and go to DONE.
  - memAck_i seen in IDLE or DONE is ignored.
- **DONE:**
  - memReq_o=0 and stallReq_o=0.
  - wData_o is the latched word for a load, or ZeroWord for a store. wReg_o=wReg_i and wRegAddr_o=wRegAddr_i.
  - Next state is IDLE, unless stallIn_i=1, in which case the FSM stays in DONE.
- Whenever wReg_i=0, wData_o and wRegAddr_o are don't-care but must be driven as ZeroWord and DisableRegAddr.
- All outputs are combinational from state and inputs. The only registers are the FSM state, the read latch, the timeout counter and busErr_o.

## Timing
- A memory access with ack in the same cycle as the request takes 2 cycles of stallReq_o=1 (IDLE cycle plus WAIT cycle), then one DONE cycle.
- In general: stall cycles = 1 + cycles spent in WAIT.
- A non-memory instruction has zero latency (combinational pass-through).
- A back-to-back memory instruction is first seen in IDLE, on the cycle after DONE.
- Reset asserted mid-WAIT:
  - The FSM returns to IDLE immediately and memReq_o drops asynchronously.
  - The in-flight access is abandoned and no write-back is produced.

## Configuration
- **With `MEM_TIMEOUT_EN` defined:**
  - An 8-bit counter runs in WAIT.
  - When it reaches TIMEOUT_CYCLES without memAck_i, the FSM goes to DONE, a load returns 16'hFFFF, and busErr_o is set.
  - busErr_o stays set until reset.
  - The counter clears on entry to WAIT.
- **Without it:** WAIT persists indefinitely until memAck_i, and the busErr_o port and counter are absent.

## Structure
- State encodings MEM_IDLE, MEM_WAIT and MEM_DONE go in `defines.v`.
- Existing bus widths and constants are reused: RegBus, MemAddrBus, RegAddrBus, ZeroWord, DisableRegAddr, RstEnable (redefined to 1'b0 for this block's reset).
- One sub-module, `mem_timeout`, holds the watchdog counter. It is instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- **ALU pass-through:** rMem=wMem=0, wReg=1, wRegAddr=3, wData=16'h1234. Required: same-cycle wData_o=16'h1234 and stallReq_o=0.
- **Load, immediate ack:** rMem=1, addr=16'h8000, ack on the first WAIT cycle with rdata=16'hBEEF. Required: stallReq_o high for 2 cycles, then DONE with wData_o=16'hBEEF.
- **Store, ack after 3 cycles:** wMem=1, addr=16'h4010, wData=16'h00A5. Required: memWe_o=1 and memWData_o=16'h00A5 held 4 cycles, then wReg_o=0.
- **stallIn_i held 2 cycles in DONE:** Required: FSM stays in DONE and wData_o stays stable.
- **Reset mid-WAIT:** rst=0 asserted mid-WAIT. Required: memReq_o=0 immediately and IDLE after release.
- **Timeout (`MEM_TIMEOUT_EN`), no ack:** Required: after 255 WAIT cycles, wData_o=16'hFFFF and busErr_o=1 sticky.
